// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Owns the fetch PC, applies EX redirects and hazard-unit stall/flush.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_d
);

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] dinstr_q, dinstr_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic        dvalid_q, dvalid_d;
    logic        dmis_q, dmis_d;
    logic        pend_q, pend_d;
    logic        fetch_ok;
    logic [31:0] fpc_plus4;

    assign fetch_ok  = imem_ready && !stall_f;
    assign fpc_plus4 = fpc_q + 32'd4;

    always_comb begin
        fpc_d    = fpc_q;
        pend_d   = pend_q;
        dinstr_d = dinstr_q;
        dpc_d    = dpc_q;
        dpc4_d   = dpc4_q;
        dvalid_d = dvalid_q;
        dmis_d   = dmis_q;

        if (pc_src_e) begin
            fpc_d  = {pc_target_e[31:2], 2'b00};
            pend_d = (pc_target_e[1:0] != 2'b00);
        end else if (fetch_ok) begin
            fpc_d = fpc_plus4;
        end

        // Squashing a wrong-path fetch keeps pc_d so the link path stays stable.
        if (pc_src_e || flush_d) begin
            dinstr_d = NOP_INSTR;
            dvalid_d = 1'b0;
            dmis_d   = 1'b0;
        end else if (stall_d) begin
            dinstr_d = dinstr_q;
        end else if (!fetch_ok) begin
            dinstr_d = NOP_INSTR;
            dvalid_d = 1'b0;
            dmis_d   = 1'b0;
        end else begin
            dinstr_d = imem_rdata;
            dpc_d    = fpc_q;
            dpc4_d   = fpc_plus4;
            dvalid_d = 1'b1;
            dmis_d   = pend_q;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            pend_q   <= 1'b0;
            dinstr_q <= NOP_INSTR;
            dpc_q    <= 32'd0;
            dpc4_q   <= 32'd0;
            dvalid_q <= 1'b0;
            dmis_q   <= 1'b0;
        end else begin
            fpc_q    <= fpc_d;
            pend_q   <= pend_d;
            dinstr_q <= dinstr_d;
            dpc_q    <= dpc_d;
            dpc4_q   <= dpc4_d;
            dvalid_q <= dvalid_d;
            dmis_q   <= dmis_d;
        end
    end

    assign pc_f       = fpc_q;
    assign imem_addr  = fpc_q;
    assign instr_d    = dinstr_q;
    assign pc_d       = dpc_q;
    assign pc_plus4_d = dpc4_q;
    assign valid_d    = dvalid_q;
    assign misalign_d = dmis_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: directed plan plus random traffic
// checked against a cycle-level reference model of the fetch stream.
module tb_fetch_ifid_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, pc_src_e, imem_ready;
    logic [31:0] pc_target_e, imem_addr, imem_rdata;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign_d;

    always #5 clk = ~clk;

    fetch_ifid_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .pc_f(pc_f), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .misalign_d(misalign_d)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F} ^ {a[7:0], 24'h0};
    endfunction

    always_comb imem_rdata = imem_ready ? mem(imem_addr) : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] dpc;
        logic [31:0] dpc4;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch unit and decode should hold after each edge.
    logic [31:0] m_pc, m_instr, m_dpc, m_dpc4;
    logic        m_valid, m_mis, m_pend;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic sf, input logic sd,
                        input logic fl, input logic ps, input logic [31:0] tg,
                        input logic rdy);
        logic fetched;
        exp_t e;
        reset = rs; stall_f = sf; stall_d = sd; flush_d = fl;
        pc_src_e = ps; pc_target_e = tg; imem_ready = rdy;
        if (rs) begin
            m_pc = RST_PC; m_pend = 0;
            m_instr = NOP; m_dpc = 0; m_dpc4 = 0; m_valid = 0; m_mis = 0;
        end else begin
            fetched = rdy && !sf;
            if (ps || fl) begin
                m_instr = NOP; m_valid = 0; m_mis = 0;
            end else if (!sd) begin
                if (fetched) begin
                    m_instr = mem(m_pc); m_dpc = m_pc; m_dpc4 = m_pc + 4;
                    m_valid = 1; m_mis = m_pend; m_pend = 0;
                end else begin
                    m_instr = NOP; m_valid = 0; m_mis = 0;
                end
            end
            if (ps) begin
                m_pc = tg & 32'hFFFF_FFFC;
                m_pend = (tg[1:0] != 0);
            end else if (fetched) begin
                m_pc = m_pc + 4;
            end
        end
        e = '{m_pc, m_instr, m_dpc, m_dpc4, m_valid, m_mis};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run();
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_f", pc_f, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("instr_d", instr_d, e.instr);
            chk("pc_d", pc_d, e.dpc);
            chk("pc_plus4_d", pc_plus4_d, e.dpc4);
            chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
            chk("misalign_d", {31'd0, misalign_d}, {31'd0, e.mis});
        end
    end

    initial begin
        int budget;
        logic [31:0] t;
        // Reset then run
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_valid", {31'd0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, NOP);
        run();
        chk("run1_pc", pc_f, 32'h4);
        chk("run1_instr", instr_d, 32'h0050_0093);
        chk("run1_pcd", pc_d, 32'h0);
        chk("run1_pc4", pc_plus4_d, 32'h4);
        run();
        chk("run2_pc", pc_f, 32'h8);
        chk("run2_instr", instr_d, 32'h00A0_0113);
        chk("run2_pcd", pc_d, 32'h4);
        // Stall both stages
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1);
        chk("stall_pc", pc_f, 32'h8);
        chk("stall_pcd", pc_d, 32'h4);
        run();
        chk("unstall_pc", pc_f, 32'hC);
        chk("unstall_pcd", pc_d, 32'h8);
        run();
        chk("pre_redir_pc", pc_f, 32'h10);
        // Redirect overriding stall_f
        step(0, 1, 0, 0, 1, 32'h100, 1);
        chk("redir_pc", pc_f, 32'h100);
        chk("redir_instr", instr_d, NOP);
        chk("redir_valid", {31'd0, valid_d}, 32'h0);
        run();
        chk("redir_pcd", pc_d, 32'h100);
        chk("redir_valid2", {31'd0, valid_d}, 32'h1);
        // Misaligned redirect
        step(0, 0, 0, 0, 1, 32'h102, 1);
        chk("mis_pc", pc_f, 32'h100);
        run();
        chk("mis_flag", {31'd0, misalign_d}, 32'h1);
        run();
        chk("mis_clear", {31'd0, misalign_d}, 32'h0);
        // imem not ready
        step(0, 0, 0, 0, 1, 32'h20, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("nrdy_pc", pc_f, 32'h20);
            chk("nrdy_valid", {31'd0, valid_d}, 32'h0);
        end
        run();
        chk("rdy_pcd", pc_d, 32'h20);
        chk("rdy_valid", {31'd0, valid_d}, 32'h1);
        // PC wrap
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        run();
        chk("wrap_pc", pc_f, 32'h0);
        chk("wrap_pc4", pc_plus4_d, 32'h0);
        // Reset beats redirect
        step(1, 0, 0, 0, 1, 32'h400, 1);
        chk("rst_redir_pc", pc_f, RST_PC);
        chk("rst_redir_valid", {31'd0, valid_d}, 32'h0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFFC;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, t, $urandom_range(0, 3) != 0);
        end
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
